cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_W, 8: program-counter width, used only for the retired-instruction counter width floor.
REQ-002 Parameter CNT_W, 16: width of the retired-instruction counter.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 rst_n  in  1: reset, synchronous and active-low.
REQ-005 start  in  1: begin execution from IDLE; ignored in all other states.
REQ-006 instr  in  9: fetched instruction; opcode = instr[8:5], imm_flag = instr[4].
REQ-007 imem_ready  in  1: instruction memory returns valid instr this cycle.
REQ-008 dmem_ready  in  1: data memory access complete this cycle.
REQ-009 br_taken  in  1: ALU branch-condition result, valid during EXEC.
REQ-010 imem_req  out  1: instruction fetch request.
REQ-011 ir_load  out  1: one-cycle pulse latching instr into the instruction register.
REQ-012 alu_en  out  1: ALU operation cycle.
REQ-013 dmem_req  out  1: data memory request; dmem_we  out  1: write qualifier.
REQ-014 reg_we  out  1: register-file write strobe.
REQ-015 pc_inc  out  1, pc_load  out  1: PC advance / PC load-target pulses, mutually exclusive.
REQ-016 halted  out  1; state_o  out  3: current state code; retired  out  CNT_W: completed-instruction count.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED; encoding is fixed in the shared package (IDLE=0 … HALTED=6).
REQ-018 IDLE: all strobes 0; start=1 → FETCH next cycle.
REQ-019 FETCH: imem_req=1 every cycle until imem_ready=1; on that cycle ir_load=1 and the opcode and imm_flag are captured internally → DECODE.
REQ-020 DECODE (1 cycle): HALT → HALTED; TBA → pc_inc=1, retired+1, → FETCH; all others → EXEC.
REQ-021 EXEC (1 cycle): alu_en=1 for ADD, SUB, SFT, INC, LHB, BNE, BEQ, BLT, JMP; alu_en=0 for LB, STR, LIM, MVB, MVF.
REQ-022 EXEC exit for LB and STR SHALL be → MEM.
REQ-023 EXEC exit for JMP SHALL be pc_load=1 → FETCH.
REQ-024 EXEC exit for BNE, BEQ and BLT SHALL be pc_load=1 if br_taken, else pc_inc=1, then → FETCH.
REQ-025 EXEC exit for all other opcodes SHALL be → WB.
REQ-026 MEM: dmem_req=1, dmem_we=(opcode==STR), held until dmem_ready=1.
REQ-027 MEM exit on dmem_ready: LB → WB; STR → pc_inc=1 → FETCH.
REQ-028 WB (1 cycle): reg_we=1, pc_inc=1 → FETCH.
REQ-029 reg_we SHALL assert only for ADD, SUB, SFT, INC, LB, LHB, MVB, MVF, LIM.
REQ-030 retired SHALL increment by 1 in exactly the cycle pc_inc or pc_load pulses, and SHALL wrap modulo 2^CNT_W.
REQ-031 HALTED: halted=1, all strobes 0; exit only by reset; start ignored.
REQ-032 A ready input arriving in a state that does not await it SHALL be ignored.
REQ-033 A ready input arriving in the same cycle as the request's first assertion SHALL complete the access with zero wait.
REQ-034 Minimum latency, fetch-to-fetch: 4 cycles for ALU/WB ops, 3 cycles for branches/JMP, 5 cycles for LB, 4 cycles for STR.

Reset
REQ-035 rst_n=0 sampled at clk edge SHALL force IDLE, zero retired, and deassert every output strobe and halted, including mid-fetch or mid-MEM; an outstanding request is abandoned.

Structure
REQ-036 The opcode constants (4-bit, LB=0 … TBA=15) and the state enum SHALL live in shared package cpu_pkg.
REQ-037 One sub-module, cpu_seq_class, SHALL be combinational and map opcode to class flags is_mem, is_store, is_branch, is_jump, writes_reg, uses_alu.

Verification
REQ-038 Reset, start=1, imem_ready=1, instr ADD (0x0E0) → ir_load@c1, alu_en@c3, reg_we+pc_inc@c4, retired=1.
REQ-039 LB with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0, then reg_we=1 once; STR → dmem_we=1, no reg_we.
REQ-040 BEQ with br_taken=1 → pc_load=1, pc_inc=0; with br_taken=0 → pc_inc=1; JMP → pc_load=1 regardless of br_taken.
REQ-041 HALT (0x1C0) → halted=1 held for 20 cycles with start pulses; retired unchanged; rst_n=0 → IDLE.
REQ-042 rst_n=0 during MEM wait → next cycle state_o=0, dmem_req=0, retired=0; preload retired to 0xFFFF with TBA → wraps to 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcode constants, state
// encoding and the opcode class record produced by the decoder.
package cpu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_LB   = 4'd0;
    localparam logic [OP_W-1:0] OP_STR  = 4'd1;
    localparam logic [OP_W-1:0] OP_LIM  = 4'd2;
    localparam logic [OP_W-1:0] OP_MVB  = 4'd3;
    localparam logic [OP_W-1:0] OP_MVF  = 4'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
    localparam logic [OP_W-1:0] OP_SFT  = 4'd6;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd7;
    localparam logic [OP_W-1:0] OP_INC  = 4'd8;
    localparam logic [OP_W-1:0] OP_LHB  = 4'd9;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd10;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'd11;
    localparam logic [OP_W-1:0] OP_BLT  = 4'd12;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd13;
    localparam logic [OP_W-1:0] OP_HALT = 4'd14;
    localparam logic [OP_W-1:0] OP_TBA  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    typedef struct packed {
        logic is_mem;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic writes_reg;
        logic uses_alu;
    } op_class_t;

endpackage

// File: rtl/cpu_seq_class.sv
// Combinational opcode classifier feeding the sequencer's EXEC/MEM/WB choices.
module cpu_seq_class
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output op_class_t       cls
);

    // Map each opcode to its class flags; unlisted codes (HALT, TBA) have none.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_LB:   begin cls.is_mem = 1'b1; cls.writes_reg = 1'b1; end
            OP_STR:  begin cls.is_mem = 1'b1; cls.is_store = 1'b1; end
            OP_LIM,
            OP_MVB,
            OP_MVF:  cls.writes_reg = 1'b1;
            OP_ADD,
            OP_SUB,
            OP_SFT,
            OP_INC,
            OP_LHB:  begin cls.uses_alu = 1'b1; cls.writes_reg = 1'b1; end
            OP_BNE,
            OP_BEQ,
            OP_BLT:  begin cls.uses_alu = 1'b1; cls.is_branch = 1'b1; end
            OP_JMP:  begin cls.uses_alu = 1'b1; cls.is_jump = 1'b1; end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch, decode, execute, memory and
// write-back phases with a retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_load,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    // Counter never narrower than the PC; the port shows the low CNT_W bits,
    // so the visible count still wraps modulo 2^CNT_W.
    localparam int RET_W = (CNT_W > PC_W) ? CNT_W : PC_W;

    state_e           state_r;
    state_e           state_s;
    logic [OP_W-1:0]  op_r;
    logic             imm_r;
    logic [RET_W-1:0] retired_r;
    op_class_t        cls_s;
    logic             unused_s;

    cpu_seq_class u_class (
        .opcode (op_r),
        .cls    (cls_s)
    );

    // The immediate flag and low instruction bits belong to the datapath.
    assign unused_s = ^{imm_r, instr[3:0]};

    assign state_o = state_r;
    assign retired = retired_r[CNT_W-1:0];

    // State, instruction-register fields and retired counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= 4'd0;
            imm_r     <= 1'b0;
            retired_r <= '0;
        end else begin
            state_r <= state_s;
            if (ir_load) begin
                op_r  <= instr[8:5];
                imm_r <= instr[4];
            end
            if (pc_inc || pc_load) begin
                retired_r <= retired_r + {{(RET_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and strobe decode; ready inputs only matter in their wait states.
    always_comb begin
        state_s  = state_r;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        halted   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_FETCH;
                else       state_s = ST_IDLE;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (op_r == OP_HALT) begin
                    state_s = ST_HALTED;
                end else if (op_r == OP_TBA) begin
                    pc_inc  = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en = cls_s.uses_alu;
                if (cls_s.is_mem) begin
                    state_s = ST_MEM;
                end else if (cls_s.is_jump) begin
                    pc_load = 1'b1;
                    state_s = ST_FETCH;
                end else if (cls_s.is_branch) begin
                    if (br_taken) pc_load = 1'b1;
                    else          pc_inc  = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls_s.is_store;
                if (!dmem_ready) begin
                    state_s = ST_MEM;
                end else if (cls_s.is_store) begin
                    pc_inc  = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_WB: begin
                reg_we  = cls_s.writes_reg;
                pc_inc  = 1'b1;
                state_s = ST_FETCH;
            end
            ST_HALTED: begin
                halted  = 1'b1;
                state_s = ST_HALTED;
            end
            default: state_s = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised self-checking bench for cpu_sequencer. Each instruction is
// expanded into its expected per-cycle strobe trace from the opcode's
// behaviour; a second narrow-counter instance exposes counter wrap.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam logic [11:0] M_IREQ = 12'h800;
    localparam logic [11:0] M_IRL  = 12'h400;
    localparam logic [11:0] M_ALU  = 12'h200;
    localparam logic [11:0] M_DREQ = 12'h100;
    localparam logic [11:0] M_DWE  = 12'h080;
    localparam logic [11:0] M_RWE  = 12'h040;
    localparam logic [11:0] M_INC  = 12'h020;
    localparam logic [11:0] M_LOAD = 12'h010;
    localparam logic [11:0] M_HALT = 12'h008;
    localparam logic [11:0] S_IDLE   = 12'd0;
    localparam logic [11:0] S_FETCH  = 12'd1;
    localparam logic [11:0] S_DECODE = 12'd2;
    localparam logic [11:0] S_EXEC   = 12'd3;
    localparam logic [11:0] S_MEM    = 12'd4;
    localparam logic [11:0] S_WB     = 12'd5;
    localparam logic [11:0] S_HALTED = 12'd6;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_ready, dmem_ready, br_taken;
    logic [8:0]  instr;
    logic        imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we, pc_inc, pc_load, halted;
    logic [2:0]  state_o;
    logic [15:0] retired;
    logic        n_imem_req, n_ir_load, n_alu_en, n_dmem_req, n_dmem_we, n_reg_we;
    logic        n_pc_inc, n_pc_load, n_halted;
    logic [2:0]  n_state_o;
    logic [7:0]  n_retired;
    logic [11:0] obs_s;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .imem_req(imem_req), .ir_load(ir_load), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
        .state_o(state_o), .retired(retired)
    );

    cpu_sequencer #(.PC_W(8), .CNT_W(8)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .imem_req(n_imem_req), .ir_load(n_ir_load), .alu_en(n_alu_en),
        .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .reg_we(n_reg_we),
        .pc_inc(n_pc_inc), .pc_load(n_pc_load), .halted(n_halted),
        .state_o(n_state_o), .retired(n_retired)
    );

    assign obs_s = {imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we,
                    pc_inc, pc_load, halted, state_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit uses_alu(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SFT, OP_INC, OP_LHB, OP_BNE, OP_BEQ, OP_BLT, OP_JMP};
    endfunction

    function automatic bit writes(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SFT, OP_INC, OP_LB, OP_LHB, OP_MVB, OP_MVF, OP_LIM};
    endfunction

    // Scramble every input the current cycle does not care about.
    task automatic rnd_junk();
        start      = 1'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        br_taken   = 1'($urandom);
        instr      = 9'($urandom);
    endtask

    // Check one cycle against its expected strobe vector, then advance the clock.
    task automatic step(input string tag, input logic [11:0] exp);
        #1;
        chk({tag, "_sig"}, {20'd0, obs_s}, {20'd0, exp});
        chk({tag, "_ret"}, {16'd0, retired}, 32'(model_cnt % 65536));
        chk({tag, "_ret8"}, {24'd0, n_retired}, 32'(model_cnt % 256));
        if (exp[5] || exp[4]) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction from FETCH to its return to FETCH (or HALTED).
    task automatic run_instr(input logic [3:0] op, input int iw, input int dw,
                             input logic br, input bit abort_mem);
        logic [11:0] alu;
        logic [11:0] we;
        for (int k = 0; k < iw; k++) begin
            rnd_junk(); imem_ready = 1'b0;
            step("fwait", S_FETCH | M_IREQ);
        end
        rnd_junk(); imem_ready = 1'b1; instr = {op, 5'($urandom)};
        step("fetch", S_FETCH | M_IREQ | M_IRL);
        rnd_junk();
        if (op == OP_HALT) begin
            step("dec_halt", S_DECODE);
        end else if (op == OP_TBA) begin
            step("dec_tba", S_DECODE | M_INC);
        end else begin
            step("dec", S_DECODE);
            rnd_junk(); br_taken = br;
            alu = uses_alu(op) ? M_ALU : 12'd0;
            if (op == OP_LB || op == OP_STR) begin
                step("exec_mem", S_EXEC | alu);
                we = (op == OP_STR) ? M_DWE : 12'd0;
                for (int k = 0; k < dw; k++) begin
                    rnd_junk(); dmem_ready = 1'b0;
                    step("mwait", S_MEM | M_DREQ | we);
                end
                if (abort_mem) begin
                    rnd_junk(); dmem_ready = 1'b0; rst_n = 1'b0;
                    step("rst_in_mem", S_MEM | M_DREQ | we);
                    model_cnt = 0;
                    rnd_junk();
                    step("rst_idle", S_IDLE);
                    rst_n = 1'b1;
                end else if (op == OP_STR) begin
                    rnd_junk(); dmem_ready = 1'b1;
                    step("mem_str", S_MEM | M_DREQ | we | M_INC);
                end else begin
                    rnd_junk(); dmem_ready = 1'b1;
                    step("mem_lb", S_MEM | M_DREQ | we);
                    rnd_junk();
                    step("wb_lb", S_WB | M_RWE | M_INC);
                end
            end else if (op == OP_JMP) begin
                step("exec_jmp", S_EXEC | alu | M_LOAD);
            end else if (op inside {OP_BNE, OP_BEQ, OP_BLT}) begin
                step("exec_br", S_EXEC | alu | (br ? M_LOAD : M_INC));
            end else begin
                step("exec", S_EXEC | alu);
                rnd_junk();
                step("wb", S_WB | (writes(op) ? M_RWE : 12'd0) | M_INC);
            end
        end
    endtask

    // Leave IDLE: one idle cycle with start low, then a start pulse.
    task automatic launch();
        rnd_junk(); start = 1'b0;
        step("idle", S_IDLE);
        rnd_junk(); start = 1'b1;
        step("idle_go", S_IDLE);
    endtask

    initial begin
        logic [3:0] op;
        rst_n = 1'b0;
        rnd_junk();
        @(posedge clk);
        #1;
        rnd_junk();
        step("reset", S_IDLE);
        rst_n = 1'b1;
        launch();

        // Directed: ADD, LB with slow memory, STR, branches, jump.
        run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        run_instr(OP_LB,  1, 3, 1'b0, 1'b0);
        run_instr(OP_STR, 0, 0, 1'b0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BEQ, 2, 0, 1'b0, 1'b0);
        run_instr(OP_JMP, 0, 0, 1'b0, 1'b0);
        run_instr(OP_JMP, 0, 0, 1'b1, 1'b0);
        run_instr(OP_MVF, 0, 0, 1'b1, 1'b0);

        // Random instruction stream, HALT excluded.
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_HALT) op = OP_TBA;
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
        end

        // Reset while waiting on data memory.
        run_instr(OP_LB, 0, 2, 1'b0, 1'b1);
        launch();

        // Long TBA run drives the narrow counter through its wrap.
        for (int i = 0; i < 260; i++) begin
            run_instr(OP_TBA, 0, 0, 1'b0, 1'b0);
        end
        run_instr(OP_SUB, 1, 0, 1'b0, 1'b0);

        // HALT holds against start pulses until reset.
        run_instr(OP_HALT, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            rnd_junk(); start = 1'(k % 2);
            step("halted", S_HALTED | M_HALT);
        end
        rnd_junk(); rst_n = 1'b0;
        step("halt_rst", S_HALTED | M_HALT);
        model_cnt = 0;
        rst_n = 1'b1;
        rnd_junk(); start = 1'b0;
        step("post_rst", S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
